// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit; the divider exists only when MD_DIV_EN is defined.
// Latency: 34 cycles accept-to-Done (divide ops without MD_DIV_EN: Done 1 cycle after accept, result 0).
// Backpressure: MD_Busy stalls the core; MD_Start is sampled only in IDLE/DONE and is never queued.
module mul_div_unit #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] MD_In_A,
    input  logic [DWIDTH-1:0] MD_In_B,
    input  logic [2:0]        MD_OP,
    input  logic              MD_Start,
    input  logic              MD_Kill,
    output logic              MD_Busy,
    output logic              MD_Done,
    output logic [DWIDTH-1:0] MD_Result
);

    localparam int W = DWIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_cnt;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic [W-1:0]    r_opd;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_result;

    logic            w_accept;
    logic            w_quick;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_b_zero;
    logic            w_neg;
    logic [W-1:0]    w_a_abs;
    logic [W-1:0]    w_b_abs;
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_prod_fix;
    logic [W-1:0]    w_fix_result;

    assign w_accept = MD_Start & ~MD_Kill & ((r_state == IDLE) | (r_state == DONE));

`ifdef MD_DIV_EN
    assign w_quick = 1'b0;
`else
    assign w_quick = MD_OP[2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_quick ? DONE : CALC;
            CALC: if (r_cnt == 5'd31) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: w_state_nxt = w_accept ? (w_quick ? DONE : CALC) : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (MD_Kill) w_state_nxt = IDLE;
    end

    // Operand conditioning: magnitudes plus the sign to restore in FIX.
    assign w_a_signed = (MD_OP == 3'b000) | (MD_OP == 3'b001) | (MD_OP == 3'b010) |
                        (MD_OP == 3'b100) | (MD_OP == 3'b110);
    assign w_b_signed = (MD_OP == 3'b000) | (MD_OP == 3'b001) |
                        (MD_OP == 3'b100) | (MD_OP == 3'b110);
    assign w_a_neg  = w_a_signed & MD_In_A[W-1];
    assign w_b_neg  = w_b_signed & MD_In_B[W-1];
    assign w_a_abs  = w_a_neg ? -MD_In_A : MD_In_A;
    assign w_b_abs  = w_b_neg ? -MD_In_B : MD_In_B;
    assign w_b_zero = (MD_In_B == '0);

    // Quotient of x/0 must stay all ones, so its sign is forced positive.
    always_comb begin
        w_neg = w_a_neg ^ w_b_neg;
        if (MD_OP[2]) begin
            w_neg = MD_OP[1] ? w_a_neg : ((w_a_neg ^ w_b_neg) & ~w_b_zero);
        end
    end

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(W+1){1'b0}});

`ifdef MD_DIV_EN
    logic [W:0] w_div_shift;
    logic [W:0] w_div_diff;
    logic       w_div_ok;
    // Remainder stays below the divisor, so bit W of the difference is the borrow.
    assign w_div_shift = {r_hi, r_lo[W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opd};
    assign w_div_ok    = ~w_div_diff[W];
`endif

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_comb begin
        w_fix_result = w_prod_fix[W-1:0];
        case (r_op)
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*W-1:W];
`ifdef MD_DIV_EN
            3'b100, 3'b101:         w_fix_result = r_neg ? -r_lo : r_lo;
            3'b110, 3'b111:         w_fix_result = r_neg ? -r_hi : r_hi;
`endif
            default:                w_fix_result = w_prod_fix[W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy <= (w_state_nxt == CALC) | (w_state_nxt == FIX);
            r_done <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_op  <= MD_OP;
                r_neg <= w_neg;
                r_cnt <= '0;
                r_hi  <= '0;
                r_lo  <= MD_OP[2] ? w_a_abs : w_b_abs;
                r_opd <= MD_OP[2] ? w_b_abs : w_a_abs;
`ifndef MD_DIV_EN
                if (MD_OP[2]) r_result <= '0;
`endif
            end else if (r_state == CALC && !MD_Kill) begin
                r_cnt <= r_cnt + 5'd1;
`ifdef MD_DIV_EN
                if (r_op[2]) begin
                    r_hi <= w_div_ok ? w_div_diff[W-1:0] : w_div_shift[W-1:0];
                    r_lo <= {r_lo[W-2:0], w_div_ok};
                end else
`endif
                begin
                    r_hi <= w_mul_sum[W:1];
                    r_lo <= {w_mul_sum[0], r_lo[W-1:1]};
                end
            end else if (r_state == FIX && !MD_Kill) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign MD_Busy   = r_busy;
    assign MD_Done   = r_done;
    assign MD_Result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed checks of mul_div_unit against a plain-arithmetic RV32M model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] MD_In_A = '0;
    logic [31:0] MD_In_B = '0;
    logic [2:0]  MD_OP = '0;
    logic        MD_Start = 1'b0;
    logic        MD_Kill = 1'b0;
    logic        MD_Busy;
    logic        MD_Done;
    logic [31:0] MD_Result;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MD_In_A(MD_In_A), .MD_In_B(MD_In_B), .MD_OP(MD_OP),
        .MD_Start(MD_Start), .MD_Kill(MD_Kill),
        .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_Result(MD_Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          si, sj;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        si = $signed(a);
        sj = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef MD_DIV_EN
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return si / sj;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return si % sj;
            end
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    // Edges after the accept edge until Done is seen, and cycles with Busy high.
    function automatic int exp_lat(input logic [2:0] op);
`ifdef MD_DIV_EN
        return 33;
`else
        return op[2] ? 0 : 33;
`endif
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n);
        @(negedge clk);
        MD_OP = op; MD_In_A = a; MD_In_B = b; MD_Start = 1'b1;
        @(posedge clk); #1;
        MD_Start = 1'b0;
        MD_In_A = $urandom; MD_In_B = $urandom; MD_OP = 3'($urandom_range(7));
        lat = 0;
        busy_n = MD_Busy ? 1 : 0;
        while (!MD_Done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (MD_Busy) busy_n++;
        end
        res = MD_Result;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (MD_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", MD_Busy); end
        total++; if (MD_Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", MD_Done); end
        total++; if (MD_Result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", MD_Result); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        vec_t        v[$];
        logic [31:0] res, want;
        int          lat, busy_n;
        v.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
        v.push_back('{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        v.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        v.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
        v.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
        v.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
        v.push_back('{3'd5, 32'd100,       32'd7,         32'd14});
        v.push_back('{3'd7, 32'd100,       32'd7,         32'd2});
        v.push_back('{3'd4, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF});
        v.push_back('{3'd6, 32'h1234_5678, 32'h0,         32'h1234_5678});
        v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        v.push_back('{3'd5, 32'hDEAD_BEEF, 32'h0,         32'hFFFF_FFFF});
        v.push_back('{3'd7, 32'h0000_0005, 32'h0,         32'h0000_0005});
        foreach (v[i]) begin
            want = v[i].r;
`ifndef MD_DIV_EN
            if (v[i].op[2]) want = 32'h0;
`endif
            do_op(v[i].op, v[i].a, v[i].b, res, lat, busy_n);
            total++; if (res !== want) begin bad++; $display("FAIL directed_result[%0d] op=%0d: got %h want %h", i, v[i].op, res, want); end
            total++; if (lat != exp_lat(v[i].op)) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_lat(v[i].op)); end
            total++; if (busy_n != exp_lat(v[i].op)) begin bad++; $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, busy_n, exp_lat(v[i].op)); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, want;
        int          lat, busy_n;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7));
            a = rand_val();
            b = rand_val();
            want = ref_md(op, a, b);
            do_op(op, a, b, res, lat, busy_n);
            total++; if (res !== want) begin bad++; $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, want); end
            total++; if (lat != exp_lat(op)) begin bad++; $display("FAIL random_latency op=%0d: got %0d want %0d", op, lat, exp_lat(op)); end
        end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int          lat, busy_n;
        bit          seen;
        do_op(3'd0, 32'd3, 32'd5, res, lat, busy_n);
        total++; if (res !== 32'd15) begin bad++; $display("FAIL kill_setup: got %h want %h", res, 32'd15); end
        @(negedge clk);
        MD_OP = 3'd0; MD_In_A = 32'd1000; MD_In_B = 32'd1000; MD_Start = 1'b1;
        @(posedge clk); #1;
        MD_Start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        MD_Kill = 1'b1;
        @(posedge clk); #1;
        MD_Kill = 1'b0;
        total++; if (MD_Busy !== 1'b0) begin bad++; $display("FAIL kill_busy: got %b want 0", MD_Busy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (MD_Done) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL kill_no_done: got done=1 want 0"); end
        total++; if (MD_Result !== 32'd15) begin bad++; $display("FAIL kill_result_held: got %h want %h", MD_Result, 32'd15); end
        @(negedge clk);
        MD_Start = 1'b1; MD_Kill = 1'b1;
        @(posedge clk); #1;
        MD_Start = 1'b0; MD_Kill = 1'b0;
        total++; if (MD_Busy !== 1'b0 || MD_Done !== 1'b0) begin bad++; $display("FAIL kill_beats_start: got busy=%b done=%b want 0 0", MD_Busy, MD_Done); end
    endtask

    task automatic test_start_while_busy();
        int  lat;
        bit  seen;
        @(negedge clk);
        MD_OP = 3'd0; MD_In_A = 32'h0001_2345; MD_In_B = 32'h0000_0111; MD_Start = 1'b1;
        @(posedge clk); #1;
        MD_Start = 1'b0;
        lat = 0;
        while (!MD_Done && lat < 100) begin
            if (lat == 5) begin MD_OP = 3'd3; MD_In_A = 32'hFFFF_FFFF; MD_In_B = 32'hFFFF_FFFF; MD_Start = 1'b1; end
            if (lat == 6) MD_Start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat != 33) begin bad++; $display("FAIL busy_start_latency: got %0d want 33", lat); end
        total++; if (MD_Result !== ref_md(3'd0, 32'h0001_2345, 32'h0000_0111)) begin
            bad++; $display("FAIL busy_start_result: got %h want %h", MD_Result, ref_md(3'd0, 32'h0001_2345, 32'h0000_0111));
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (MD_Done) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL busy_start_not_queued: got extra done want none"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, res1, res2;
        int          lat, busy_n;
        a1 = $urandom; b1 = $urandom | 32'h1;
        a2 = $urandom; b2 = $urandom;
        do_op(3'd5, a1, b1, res1, lat, busy_n);
        total++; if (res1 !== ref_md(3'd5, a1, b1)) begin bad++; $display("FAIL b2b_first: got %h want %h", res1, ref_md(3'd5, a1, b1)); end
        MD_OP = 3'd1; MD_In_A = a2; MD_In_B = b2; MD_Start = 1'b1;
        @(posedge clk); #1;
        MD_Start = 1'b0;
        lat = 0;
        while (!MD_Done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res2 = MD_Result;
        total++; if (lat != 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        total++; if (res2 !== ref_md(3'd1, a2, b2)) begin bad++; $display("FAIL b2b_second: got %h want %h", res2, ref_md(3'd1, a2, b2)); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        MD_OP = 3'd0; MD_In_A = 32'h0000_1234; MD_In_B = 32'h0000_5678; MD_Start = 1'b1;
        @(posedge clk); #1;
        MD_Start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (MD_Busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", MD_Busy); end
        total++; if (MD_Done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", MD_Done); end
        total++; if (MD_Result !== 32'h0) begin bad++; $display("FAIL midreset_result: got %h want 0", MD_Result); end
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (MD_Done || MD_Busy) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL midreset_idle: got activity want none"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
